// File: rtl/srch_seg_acc.sv
// srch_seg_acc: groups the REs of one search block into 90 kHz segments
// and emits the summed power |I|^2+|Q|^2 and RE count of each segment.
module srch_seg_acc #(
  parameter int DW = 16,
  parameter int PW = 2*DW+5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           scs,
  input  logic                 re_vld,
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] re_q,
  output logic                 busy,
  output logic                 seg_vld,
  output logic [3:0]           seg_idx,
  output logic [4:0]           seg_nre,
  output logic [PW-1:0]        seg_pwr,
  output logic                 blk_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Unsigned power of one complex sample; the sum of two squares of
  // DW-bit signed values always fits in 2*DW unsigned bits.
  function automatic logic [2*DW-1:0] re_power(input logic signed [DW-1:0] i,
                                               input logic signed [DW-1:0] q);
    logic signed [2*DW-1:0] iw, qw, ii, qq;
    iw = (2*DW)'(i);
    qw = (2*DW)'(q);
    ii = iw * iw;
    qq = qw * qw;
    return $unsigned(ii) + $unsigned(qq);
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      scs_q, scs_d;
  logic [7:0]      re_cnt_q, re_cnt_d;
  logic [4:0]      in_seg_q, in_seg_d;
  logic [3:0]      seg_cnt_q, seg_cnt_d;
  logic            accept;

  logic [4:0]      gap_m1;
  logic [7:0]      last_re;
  logic            tag_first, tag_last_seg, tag_last_blk;

  logic            vld_p1;
  logic [2*DW-1:0] p_p1;
  logic            first_p1, last_seg_p1, last_blk_p1;
  logic [3:0]      idx_p1;
  logic [4:0]      nre_p1;
  logic [PW-1:0]   acc_p2, acc_nxt;

  logic            seg_vld_q, blk_done_q;
  logic [3:0]      seg_idx_q;
  logic [4:0]      seg_nre_q;
  logic [PW-1:0]   seg_pwr_q;

  // Segment width and last RE index of the block for the latched scs.
  always_comb begin
    gap_m1  = 5'd2;
    last_re = 8'd31;
    case (scs_q)
      2'd1:    begin gap_m1 = 5'd17; last_re = 8'd255; end
      2'd2:    begin gap_m1 = 5'd5;  last_re = 8'd63;  end
      default: begin gap_m1 = 5'd2;  last_re = 8'd31;  end
    endcase
  end

  assign tag_first    = (in_seg_q == 5'd0);
  assign tag_last_blk = (re_cnt_q == last_re);
  assign tag_last_seg = (in_seg_q == gap_m1) || tag_last_blk;

  // Next state and RE/segment counters; start always (re)starts or aborts.
  always_comb begin
    state_d   = state_q;
    scs_d     = scs_q;
    re_cnt_d  = re_cnt_q;
    in_seg_d  = in_seg_q;
    seg_cnt_d = seg_cnt_q;
    accept    = 1'b0;
    if (start) begin
      if (scs != 2'd0) begin
        state_d   = S_RUN;
        scs_d     = scs;
        re_cnt_d  = 8'd0;
        in_seg_d  = 5'd0;
        seg_cnt_d = 4'd0;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (re_vld) begin
            accept   = 1'b1;
            re_cnt_d = re_cnt_q + 8'd1;
            if (in_seg_q == gap_m1) begin
              in_seg_d  = 5'd0;
              seg_cnt_d = seg_cnt_q + 4'd1;
            end else begin
              in_seg_d = in_seg_q + 5'd1;
            end
            if (tag_last_blk) state_d = S_DRAIN;
          end
        end
        S_DRAIN: if (blk_done_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign acc_nxt = first_p1 ? PW'(p_p1) : acc_p2 + PW'(p_p1);

  // Control state, pipeline valids and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scs_q      <= 2'd0;
      re_cnt_q   <= 8'd0;
      in_seg_q   <= 5'd0;
      seg_cnt_q  <= 4'd0;
      vld_p1     <= 1'b0;
      seg_vld_q  <= 1'b0;
      blk_done_q <= 1'b0;
      seg_idx_q  <= 4'd0;
      seg_nre_q  <= 5'd0;
      seg_pwr_q  <= '0;
    end else begin
      state_q    <= state_d;
      scs_q      <= scs_d;
      re_cnt_q   <= re_cnt_d;
      in_seg_q   <= in_seg_d;
      seg_cnt_q  <= seg_cnt_d;
      vld_p1     <= accept;
      seg_vld_q  <= 1'b0;
      blk_done_q <= 1'b0;
      // stage 2: close a segment unless an abort is flushing the pipe
      if (vld_p1 && last_seg_p1 && !start) begin
        seg_vld_q  <= 1'b1;
        blk_done_q <= last_blk_p1;
        seg_idx_q  <= idx_p1;
        seg_nre_q  <= nre_p1;
        seg_pwr_q  <= acc_nxt;
      end
    end
  end

  // Stage 1 power/tag registers and stage 2 accumulator (data only).
  always_ff @(posedge clk) begin
    // stage 1: power term and segment tags of the accepted RE
    if (accept) begin
      p_p1        <= re_power(re_i, re_q);
      first_p1    <= tag_first;
      last_seg_p1 <= tag_last_seg;
      last_blk_p1 <= tag_last_blk;
      idx_p1      <= seg_cnt_q;
      nre_p1      <= in_seg_q + 5'd1;
    end
    // stage 2: running segment sum
    if (vld_p1) acc_p2 <= acc_nxt;
  end

  assign busy     = (state_q != S_IDLE);
  assign seg_vld  = seg_vld_q;
  assign seg_idx  = seg_idx_q;
  assign seg_nre  = seg_nre_q;
  assign seg_pwr  = seg_pwr_q;
  assign blk_done = blk_done_q;

endmodule

// File: tb/tb_srch_seg_acc.sv
// Scoreboard bench for srch_seg_acc: a division-based segment model pushes
// expected results; a negedge monitor pops and compares each seg_vld.
module tb_srch_seg_acc;
  localparam int DW = 16;
  localparam int PW = 2*DW+5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [1:0]           scs = 2'd0;
  logic                 re_vld = 1'b0;
  logic signed [DW-1:0] re_i = '0;
  logic signed [DW-1:0] re_q = '0;
  logic                 busy, seg_vld, blk_done;
  logic [3:0]           seg_idx;
  logic [4:0]           seg_nre;
  logic [PW-1:0]        seg_pwr;

  srch_seg_acc #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .scs(scs), .re_vld(re_vld),
    .re_i(re_i), .re_q(re_q), .busy(busy), .seg_vld(seg_vld),
    .seg_idx(seg_idx), .seg_nre(seg_nre), .seg_pwr(seg_pwr), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [4:0]  nre;
    logic [63:0] pwr;
    logic        done;
  } exp_t;

  exp_t               sb[$];
  int                 n_chk = 0;
  int                 n_pass = 0;
  int                 n_pulse = 0;
  int                 cyc = 0;
  int                 last_cyc = 0;
  int                 blk_p0 = 0;
  logic               busy_or = 1'b0;
  logic signed [15:0] ri[256];
  logic signed [15:0] rq[256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every seg_vld must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (seg_vld) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_seg: idx %0d nre %0d pwr %0d with nothing expected",
                 seg_idx, seg_nre, seg_pwr);
      end else begin
        e = sb.pop_front();
        chk("seg_idx", 64'(seg_idx), 64'(e.idx));
        chk("seg_nre", 64'(seg_nre), 64'(e.nre));
        chk("seg_pwr", 64'(seg_pwr), e.pwr);
        chk("blk_done", 64'(blk_done), 64'(e.done));
      end
    end else if (blk_done) begin
      n_chk++;
      $display("FAIL lone_blk_done: blk_done=1 without seg_vld");
    end
  end

  // Reference: segment = k / gap, results for segments closed at RE <= cut.
  task automatic model_push(input int s, input int n_acc, input int cut, output int npush);
    longint sum[16];
    int     cnt[16];
    int     gap, ntot, sg;
    exp_t   e;
    gap  = (s == 1) ? 18 : (s == 2) ? 6 : 3;
    ntot = (s == 1) ? 256 : (s == 2) ? 64 : 32;
    npush = 0;
    for (int j = 0; j < 16; j++) begin sum[j] = 0; cnt[j] = 0; end
    for (int k = 0; k < n_acc; k++) begin
      sg = k / gap;
      sum[sg] += longint'(ri[k]) * ri[k] + longint'(rq[k]) * rq[k];
      cnt[sg]++;
      if (((k % gap) == gap - 1 || k == ntot - 1) && k <= cut) begin
        e.idx  = 4'(sg);
        e.nre  = 5'(cnt[sg]);
        e.pwr  = 64'(sum[sg]);
        e.done = (k == ntot - 1);
        sb.push_back(e);
        npush++;
      end
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < 256; k++) begin
      case (pat)
        0:       begin ri[k] = 16'sd1;      rq[k] = 16'sd0; end
        1:       begin ri[k] = -16'sd32768; rq[k] = -16'sd32768; end
        2:       begin ri[k] = 16'(k);      rq[k] = 16'sd0; end
        default: begin ri[k] = 16'($urandom); rq[k] = 16'($urandom); end
      endcase
    end
  endtask

  // Called at a negedge: one-cycle start pulse.
  task automatic start_block(input int s);
    start  = 1'b1;
    scs    = 2'(s);
    re_vld = 1'b0;
    @(negedge clk);
    busy_or |= busy;
    start  = 1'b0;
    blk_p0 = n_pulse;
  endtask

  // gm: 0 back-to-back, 1 every other cycle, 2 random gaps.
  task automatic drive_res(input int n, input int gm);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && gm == 1) begin
        re_vld = 1'b0;
        @(negedge clk);
        busy_or |= busy;
      end
      if (k > 0 && gm == 2 && $urandom_range(0, 3) == 0) begin
        re_vld = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          busy_or |= busy;
        end
      end
      re_vld = 1'b1;
      re_i   = ri[k];
      re_q   = rq[k];
      @(negedge clk);
      busy_or |= busy;
      last_cyc = cyc;
    end
    re_vld = 1'b0;
  endtask

  task automatic finish_block(input int npush);
    logic got;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (blk_done) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL blk_done_timeout: no blk_done within 20 cycles");
    end else begin
      chk("blk_done_latency", 64'(cyc - last_cyc), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("seg_pulses", 64'(n_pulse - blk_p0), 64'(npush));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, p0, s;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_seg_vld", 64'(seg_vld), 64'd0);
    chk("rst_seg_idx", 64'(seg_idx), 64'd0);
    chk("rst_seg_nre", 64'(seg_nre), 64'd0);
    chk("rst_seg_pwr", 64'(seg_pwr), 64'd0);
    chk("rst_blk_done", 64'(blk_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // scs=3, I=1 Q=0, back-to-back
    fill(0); start_block(3); model_push(3, 32, 31, np); drive_res(32, 0); finish_block(np);
    // scs=2, full-scale negative samples
    fill(1); start_block(2); model_push(2, 64, 63, np); drive_res(64, 0); finish_block(np);
    // scs=1, ramp, re_vld every other cycle
    fill(2); start_block(1); model_push(1, 256, 255, np); drive_res(256, 1); finish_block(np);

    // abort a scs=3 block after 10 REs with a scs=2 start
    fill(3); start_block(3); model_push(3, 10, 8, np); drive_res(10, 0);
    fill(3); start_block(2); model_push(2, 64, 63, np); drive_res(64, 2); finish_block(np);

    // asynchronous reset in the middle of a scs=1 block
    fill(3); start_block(1); model_push(1, 40, 38, np); drive_res(40, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_seg_vld", 64'(seg_vld), 64'd0);
    chk("arst_seg_idx", 64'(seg_idx), 64'd0);
    chk("arst_seg_nre", 64'(seg_nre), 64'd0);
    chk("arst_seg_pwr", 64'(seg_pwr), 64'd0);
    chk("arst_blk_done", 64'(blk_done), 64'd0);
    chk("arst_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    busy_or = 1'b0; p0 = n_pulse;
    drive_res(20, 0);
    repeat (3) @(negedge clk);
    chk("nostart_busy", 64'(busy_or), 64'd0);
    chk("nostart_pulses", 64'(n_pulse - p0), 64'd0);
    fill(3); start_block(3); model_push(3, 32, 31, np); drive_res(32, 2); finish_block(np);

    // start with scs=0 is ignored
    busy_or = 1'b0; p0 = n_pulse;
    fill(3); start_block(0); drive_res(32, 0);
    repeat (3) @(negedge clk);
    chk("scs0_busy", 64'(busy_or), 64'd0);
    chk("scs0_pulses", 64'(n_pulse - p0), 64'd0);

    // random blocks
    repeat (6) begin
      s = $urandom_range(1, 3);
      fill(3); start_block(s);
      model_push(s, (s == 1) ? 256 : (s == 2) ? 64 : 32, 255, np);
      drive_res((s == 1) ? 256 : (s == 2) ? 64 : 32, 2);
      finish_block(np);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
